// File: rtl/gf_sel_pkg.sv
// Shared defaults and FSM encoding for the select-path arbiter.
// Pure declarations: no logic, no latency, no flow control.
package gf_sel_pkg;

    localparam int N_REQ_DEF     = 8;
    localparam int SEL_W_DEF     = 3;
    localparam int DRAIN_CYC_DEF = 2;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sel_arbiter_if.sv
// Requester/arbiter bundle: requests, packet framing, backpressure and grant status.
// master drives the request side; slave is the arbiter.
interface sel_arbiter_if
    import gf_sel_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic             hold;
    logic             clr_err;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic             err;

    modport master (
        output req, last, hold, clr_err,
        input  gnt, sel, sel_valid, busy, pkt_cnt, err
    );

    modport slave (
        input  req, last, hold, clr_err,
        output gnt, sel, sel_valid, busy, pkt_cnt, err
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first asserted request at or after ptr, wrapping at N_REQ-1.
// Purely combinational, zero latency, no backpressure.
module rr_pick #(
    parameter int N_REQ = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(N_REQ)) begin
                cand = cand - (SEL_W+1)'(N_REQ);
            end
            if (req[cand[SEL_W-1:0]]) begin
                idx   = cand[SEL_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sel_arbiter.sv
// Packet-granular round-robin arbiter for a shared select path; grant registered one cycle after request.
// hold stalls the granted packet in place; each packet is followed by DRAIN_CYC cycles with sel frozen.
module sel_arbiter
    import gf_sel_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sel_arbiter_if.slave  bus
);

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic [SEL_W-1:0] sel_inc;
    logic             drop;
    logic             xfer_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel_inc   = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
    assign drop      = ~bus.req[sel_q];
    assign xfer_last = bus.req[sel_q] & ~bus.hold & bus.last[sel_q];

    // A dropped request ends the packet even under hold, so the path is never left stuck.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        drain_d   = drain_q;
        pkt_cnt_d = pkt_cnt_q;
        err_d     = err_q & ~bus.clr_err;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = N_REQ'(1) << pick_idx;
                end
            end
            GRANT: begin
                if (drop || xfer_last) begin
                    state_d = (DRAIN_CYC == 0) ? IDLE : DRAIN;
                    ptr_d   = sel_inc;
                    gnt_d   = '0;
                    drain_d = '0;
                    if (drop) begin
                        err_d = 1'b1;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            drain_q   <= '0;
            pkt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            drain_q   <= drain_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = (state_q == GRANT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// Bench for sel_arbiter: behavioural requesters, expected grant order queued at stimulus time.
module tb_sel_arbiter;
    import gf_sel_pkg::*;

    localparam int N  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sel_arbiter_if #(.N_REQ(N), .SEL_W(SW)) bus ();

    sel_arbiter #(.N_REQ(N), .SEL_W(SW), .DRAIN_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         words [N];
    bit         reload [N];
    logic [N-1:0] drop_m;
    logic [N-1:0] xfer;
    int         exp_q [$];
    int         cyc = 0;
    bit         prev_vld = 1'b0;
    int         last_start = 0;
    bit         gap_en = 1'b0;
    int         n_starts = 0;
    int         n_gcyc = 0;
    int         n_dcyc = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.req[k]  = (words[k] != 0) && !drop_m[k];
            bus.last[k] = (words[k] == 1);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) begin
            if (words[k] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic monitor();
        int e;
        if (bus.sel_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_sel", 32'(bus.sel), 32'(e));
                check("sb_gnt", 32'(bus.gnt), 32'd1 << e);
            end
            if (gap_en && n_starts > 0) check("grant_gap", 32'(cyc - last_start), 32'd4);
            n_starts++;
            last_start = cyc;
        end
        if (bus.sel_valid) n_gcyc++;
        if (bus.busy && !bus.sel_valid) n_dcyc++;
        prev_vld = bus.sel_valid;
    endtask

    // Inputs change only at posedge+1; outputs and the transfer condition are sampled at negedge.
    task automatic tick();
        @(negedge clk);
        monitor();
        xfer = bus.gnt & bus.req & {N{~bus.hold}};
        cyc++;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (xfer[k] && words[k] > 0) begin
                words[k]--;
                if (words[k] == 0 && reload[k]) words[k] = 1;
            end
        end
        drive();
    endtask

    task automatic wait_idle(string tag, int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.busy || pending()) && n < budget);
        check({tag, "_idle"}, {30'd0, bus.busy, pending()}, 32'd0);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < N; k++) begin
            words[k]  = 0;
            reload[k] = 1'b0;
        end
        drop_m      = '0;
        bus.hold    = 1'b0;
        bus.clr_err = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_stim();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_gnt"},       32'(bus.gnt),       32'h0);
        check({tag, "_sel"},       32'(bus.sel),       32'h0);
        check({tag, "_sel_valid"}, 32'(bus.sel_valid), 32'h0);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
        check({tag, "_pkt_cnt"},   32'(bus.pkt_cnt),   32'h0);
        check({tag, "_err"},       32'(bus.err),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required finish before 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stim();
        repeat (2) tick();
        check_reset_vals("rst");
        rst = 1'b0;

        // 3-word packet from requester 2
        n_gcyc = 0;
        n_dcyc = 0;
        words[2] = 3;
        exp_q.push_back(2);
        drive();
        wait_idle("a", 20);
        check("a_grant_cycles", 32'(n_gcyc), 32'd3);
        check("a_drain_cycles", 32'(n_dcyc), 32'd2);
        check("a_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);

        // pointer now 3: requesters 2 and 4 -> 4 wins, then 2
        words[2] = 1;
        words[4] = 1;
        exp_q.push_back(4);
        exp_q.push_back(2);
        drive();
        wait_idle("a2", 30);
        check("a2_pkt_cnt", 32'(bus.pkt_cnt), 32'd3);

        // all requesters, 1-word packets, from a fresh reset
        do_reset();
        for (int k = 0; k < N; k++) begin
            words[k]  = 1;
            reload[k] = 1'b1;
            exp_q.push_back(k);
        end
        exp_q.push_back(0);
        gap_en   = 1'b1;
        n_starts = 0;
        drive();
        for (int i = 0; i < 100 && n_starts < 9; i++) tick();
        clear_stim();
        gap_en = 1'b0;
        wait_idle("b", 20);
        check("b_grants", 32'(n_starts), 32'd9);
        check("b_pkt_cnt", 32'(bus.pkt_cnt), 32'd9);

        // requester 5 stalled by hold for 4 cycles mid-packet
        n_gcyc = 0;
        words[5] = 4;
        exp_q.push_back(5);
        drive();
        tick();
        tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("c_hold_gnt", 32'(bus.gnt), 32'h20);
            check("c_hold_pkt", 32'(bus.pkt_cnt), 32'd9);
        end
        bus.hold = 1'b0;
        wait_idle("c", 20);
        check("c_pkt_cnt", 32'(bus.pkt_cnt), 32'd10);
        check("c_grant_cycles", 32'(n_gcyc), 32'd8);

        // requester 1 drops before its last word
        words[1] = 3;
        exp_q.push_back(1);
        drive();
        tick();
        tick();
        drop_m[1] = 1'b1;
        drive();
        tick();
        check("d_err", 32'(bus.err), 32'd1);
        check("d_sel_valid", 32'(bus.sel_valid), 32'd0);
        check("d_busy", 32'(bus.busy), 32'd1);
        check("d_pkt_cnt", 32'(bus.pkt_cnt), 32'd10);
        drop_m   = '0;
        words[1] = 0;
        drive();
        wait_idle("d", 10);
        check("d_err_sticky", 32'(bus.err), 32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("d_err_clr", 32'(bus.err), 32'd0);

        // drop under hold with clr_err in the same cycle: the new error wins
        words[3] = 2;
        exp_q.push_back(3);
        drive();
        tick();
        tick();
        bus.hold    = 1'b1;
        bus.clr_err = 1'b1;
        drop_m[3]   = 1'b1;
        drive();
        tick();
        check("e_err_wins", 32'(bus.err), 32'd1);
        check("e_sel_valid", 32'(bus.sel_valid), 32'd0);
        check("e_pkt_cnt", 32'(bus.pkt_cnt), 32'd10);
        clear_stim();
        wait_idle("e", 10);

        // reset in the middle of requester 6's packet
        words[6] = 5;
        exp_q.push_back(6);
        drive();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("f_async");
        clear_stim();
        repeat (2) tick();
        rst = 1'b0;
        words[6] = 1;
        words[7] = 1;
        exp_q.push_back(6);
        exp_q.push_back(7);
        drive();
        wait_idle("f", 30);
        check("f_pkt_cnt", 32'(bus.pkt_cnt), 32'd2);
        check("f_err", 32'(bus.err), 32'd0);

        // counter wrap from 0xFFFF
        force dut.pkt_cnt_q = 16'hFFFF;
        tick();
        release dut.pkt_cnt_q;
        check("g_preload", 32'(bus.pkt_cnt), 32'hFFFF);
        words[0] = 1;
        exp_q.push_back(0);
        drive();
        wait_idle("g", 20);
        check("g_wrap", 32'(bus.pkt_cnt), 32'h0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 Parameter N_REQ, default 8, number of requesters sharing the select path.
REQ-002 Parameter SEL_W, default 3, select width, equal to clog2(N_REQ).
REQ-003 Parameter DRAIN_CYC, default 2, idle cycles after a grant during which SEL is held stable so the downstream select pipeline empties.
REQ-004 CLOCK  in  1  single clock; all flops on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 REQ  in  N_REQ  request per requester; level, held until the packet ends.
REQ-007 LAST  in  N_REQ  marks the requester's current word as the last of its packet.
REQ-008 HOLD  in  1  downstream backpressure; when 1, no word transfers.
REQ-009 CLR_ERR  in  1  synchronous clear of ERR.
REQ-010 GNT  out  N_REQ  one-hot grant, registered.
REQ-011 SEL  out  SEL_W  index of the granted requester, registered.
REQ-012 SEL_VALID  out  1  1 only while in GRANT.
REQ-013 BUSY  out  1  1 in GRANT or DRAIN.
REQ-014 PKT_CNT  out  16  completed-packet count, wraps 0xFFFF->0x0000.
REQ-015 ERR  out  1  sticky protocol-error flag.

Function
REQ-016 FSM states: IDLE, GRANT, DRAIN.
REQ-017 Transfer: a cycle in GRANT with GNT[k]=1, REQ[k]=1 and HOLD=0.
REQ-018 IDLE, any REQ=1: pick the first k with REQ[k]=1, searching upward from PTR with wrap N_REQ-1->0. Next cycle: GRANT, GNT=1<<k, SEL=k, SEL_VALID=1.
REQ-019 IDLE, no REQ: stay in IDLE; GNT=0; SEL_VALID=0; SEL keeps its last value.
REQ-020 GRANT, HOLD=1: stall; GNT, SEL and state unchanged.
REQ-021 GRANT, transfer with LAST[k]=1: PKT_CNT+1, PTR=(k+1) mod N_REQ, go to DRAIN next cycle.
REQ-022 GRANT, REQ[k]=0: set ERR, PTR=(k+1) mod N_REQ, go to DRAIN; PKT_CNT unchanged.
REQ-023 GRANT, REQ[k]=0 and HOLD=1 in the same cycle: treat per REQ-022 (drop wins).
REQ-024 LAST on non-granted requesters is ignored.
REQ-025 DRAIN: GNT=0, SEL_VALID=0, SEL held, for exactly DRAIN_CYC cycles; then IDLE. Minimum packet-to-packet gap is DRAIN_CYC+1 cycles.
REQ-026 Round-robin fairness: with all REQ held high, grants rotate 0,1,...,N_REQ-1,0.
REQ-027 CLR_ERR=1 clears ERR next cycle; a new error in the same cycle wins (ERR=1).
REQ-028 GNT is always zero or one-hot; SEL_VALID=1 implies GNT[SEL]=1.

Reset
REQ-029 RESET=1 forces immediately: state IDLE, PTR=0, GNT=0, SEL=0, SEL_VALID=0, BUSY=0, PKT_CNT=0, ERR=0.
REQ-030 RESET during GRANT or DRAIN aborts the packet with no PKT_CNT update and no ERR.
REQ-031 After RESET falls, arbitration resumes on the first rising edge with PTR=0.

Structure
REQ-032 Shared package gf_sel_pkg holds N_REQ, SEL_W, DRAIN_CYC defaults and the state encoding (IDLE=2'd0, GRANT=2'd1, DRAIN=2'd2).
REQ-033 Sub-module rr_pick: combinational; inputs REQ and PTR; outputs index and found flag; no state.
REQ-034 sel_arbiter holds the FSM, PTR, drain counter, PKT_CNT, ERR and output registers.

Verification
REQ-035 REQ=0x04 from reset, 3 words, LAST on the 3rd -> GNT=0x04, SEL=2 for 3 cycles, then 2 DRAIN cycles, PKT_CNT=1, PTR=3.
REQ-036 REQ=0xFF held, 1-word packets -> SEL sequence 0,1,...,7,0; each grant separated by 3 cycles; PKT_CNT=9 after 9 grants.
REQ-037 Granted k=5, HOLD=1 for 4 cycles in mid-packet -> GNT=0x20 stable, no PKT_CNT change; packet completes after HOLD falls.
REQ-038 Granted k=1, REQ[1] drops before LAST -> ERR=1, DRAIN, PKT_CNT unchanged; CLR_ERR pulse -> ERR=0.
REQ-039 RESET asserted mid-GRANT (k=6) -> all outputs at reset values asynchronously; after release, REQ=0xC0 grants k=6 first.
REQ-040 PKT_CNT preloaded via 65535 packets, one more packet -> PKT_CNT=0x0000.
